// File: rtl/cam_search_ctrl.sv
// rtl/cam_search_ctrl.sv - single-outstanding CAM search sequencer with priority match encoder
// Optional res_count output and logic enabled by defining CAM_MATCH_COUNT_EN.
module cam_search_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [DATA_WIDTH-1:0]     req_key,
  output logic                      req_ready,
  output logic [DATA_WIDTH-1:0]     cam_key,
  input  logic [(2**ADDR_WIDTH)-1:0] cam_match_n,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_hit,
  output logic [ADDR_WIDTH-1:0]     res_addr,
  output logic                      res_multi
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]       res_count
`endif
);

  localparam int N = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ENCODE = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic load_key;
  logic load_res;

  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_addr;
  logic                  enc_multi;
  logic [ADDR_WIDTH:0]   enc_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = WAIT;
      WAIT:    state_next = ENCODE;
      ENCODE:  state_next = RESULT;
      RESULT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // req_ready is masked by rst so nothing is offered while reset is held.
  always_comb begin
    req_ready = 1'b0;
    res_valid = 1'b0;
    load_key  = 1'b0;
    load_res  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        load_key  = req_valid & ~rst;
      end
      ENCODE:  load_res  = 1'b1;
      RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // Scanning from the top down leaves the lowest matching index in enc_addr.
  always_comb begin
    enc_addr  = '0;
    enc_count = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!cam_match_n[i]) begin
        enc_addr  = ADDR_WIDTH'(i);
        enc_count = enc_count + (ADDR_WIDTH+1)'(1);
      end
    end
    enc_hit   = ~&cam_match_n;
    enc_multi = (enc_count > (ADDR_WIDTH+1)'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_key <= '0;
    end else if (load_key) begin
      cam_key <= req_key;
    end
  end

  // Results are captured once in ENCODE, so later RAM activity cannot disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_hit   <= 1'b0;
      res_addr  <= '0;
      res_multi <= 1'b0;
    end else if (load_res) begin
      res_hit   <= enc_hit;
      res_addr  <= enc_addr;
      res_multi <= enc_multi;
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_count <= '0;
    end else if (load_res) begin
      res_count <= enc_count;
    end
  end
`endif

endmodule

// File: tb/tb_cam_search_ctrl.sv
// tb/tb_cam_search_ctrl.sv - directed vector bench for cam_search_ctrl
module tb_cam_search_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_key;
  logic       req_ready;
  logic [7:0] cam_key;
  logic [3:0] cam_match_n;
  logic       res_valid;
  logic       res_ready;
  logic       res_hit;
  logic [1:0] res_addr;
  logic       res_multi;
`ifdef CAM_MATCH_COUNT_EN
  logic [2:0] res_count;
`endif

  int checks   = 0;
  int failures = 0;

  cam_search_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_key     (req_key),
    .req_ready   (req_ready),
    .cam_key     (cam_key),
    .cam_match_n (cam_match_n),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hit     (res_hit),
    .res_addr    (res_addr),
    .res_multi   (res_multi)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .res_count   (res_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [3:0] match_n;
    logic       hit;
    logic [1:0] addr;
    logic       multi;
    logic [2:0] count;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, "_hit"},   32'(res_hit),   32'(v.hit));
    chk({tag, "_addr"},  32'(res_addr),  32'(v.addr));
    chk({tag, "_multi"}, 32'(res_multi), 32'(v.multi));
`ifdef CAM_MATCH_COUNT_EN
    chk({tag, "_count"}, 32'(res_count), 32'(v.count));
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Garbage is presented on cam_match_n outside ENCODE to prove the single sample point.
  task automatic run_search(input vec_t v, input int hold);
    wait_ready();
    req_valid   = 1'b1;
    req_key     = v.key;
    res_ready   = 1'b0;
    cam_match_n = ~v.match_n;
    step();
    req_valid = 1'b0;
    chk("cam_key_after_accept", 32'(cam_key), 32'(v.key));
    chk("busy_in_wait", 32'(req_ready), 32'd0);
    chk("no_valid_in_wait", 32'(res_valid), 32'd0);
    step();
    chk("no_valid_in_encode", 32'(res_valid), 32'd0);
    cam_match_n = v.match_n;
    step();
    chk("valid_latency3", 32'(res_valid), 32'd1);
    chk_result("res", v);
    cam_match_n = ~v.match_n;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("valid_held", 32'(res_valid), 32'd1);
      chk_result("held", v);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("valid_drop", 32'(res_valid), 32'd0);
    chk("ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts[$];
    vec_t hv;

    vecs[0] = '{8'h3C, 4'b1011, 1'b1, 2'd2, 1'b0, 3'd1};
    vecs[1] = '{8'h55, 4'b0101, 1'b1, 2'd1, 1'b1, 3'd2};
    vecs[2] = '{8'hA5, 4'b1111, 1'b0, 2'd0, 1'b0, 3'd0};
    vecs[3] = '{8'h01, 4'b0000, 1'b1, 2'd0, 1'b1, 3'd4};
    vecs[4] = '{8'hFE, 4'b0111, 1'b1, 2'd3, 1'b0, 3'd1};
    vecs[5] = '{8'h11, 4'b1100, 1'b1, 2'd0, 1'b1, 3'd2};

    rst = 1'b1; req_valid = 1'b0; req_key = 8'h00; res_ready = 1'b0; cam_match_n = 4'b1111;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cam_key",   32'(cam_key),   32'd0);
    chk("rst_res_hit",   32'(res_hit),   32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_search(vecs[i], 1);

    // Result held under backpressure while a new request is ignored.
    hv = vecs[0];
    wait_ready();
    req_valid = 1'b1; req_key = hv.key; res_ready = 1'b0; cam_match_n = hv.match_n;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("bp_valid", 32'(res_valid), 32'd1);
    req_valid = 1'b1; req_key = 8'hAA; cam_match_n = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", 32'(res_valid), 32'd1);
      chk("bp_req_ready",  32'(req_ready), 32'd0);
      chk("bp_cam_key",    32'(cam_key),   32'h3C);
      chk_result("bp", hv);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_valid_drop", 32'(res_valid), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_key_not_taken", 32'(cam_key), 32'h3C);

    // Reset during ENCODE discards the search.
    req_valid = 1'b1; req_key = 8'h5A; cam_match_n = 4'b1110;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstenc_valid",   32'(res_valid), 32'd0);
    chk("rstenc_cam_key", 32'(cam_key),   32'd0);
    chk("rstenc_hit",     32'(res_hit),   32'd0);
    chk("rstenc_addr",    32'(res_addr),  32'd0);
    chk("rstenc_multi",   32'(res_multi), 32'd0);
`ifdef CAM_MATCH_COUNT_EN
    chk("rstenc_count",   32'(res_count), 32'd0);
`endif
    #1;
    chk("rstenc_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstenc_no_pulse", 32'(res_valid), 32'd0);
    end

    // Back-to-back throughput with res_ready tied high.
    res_ready = 1'b1; req_valid = 1'b1; req_key = 8'h77; cam_match_n = 4'b1110;
    for (int c = 0; c < 16; c++) begin
      if (req_ready) accepts.push_back(c);
      step();
    end
    req_valid = 1'b0;
    res_ready = 1'b0;
    chk("tp_accepts", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++)
      chk("tp_spacing", 32'(accepts[i] - accepts[i-1]), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_search_ctrl.md
CAM_SEARCH_CTRL -- requirements
Module: cam_search_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: key width, equal to the CAM RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2: entry address width; the match vector is 2**ADDR_WIDTH bits (N).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: search request present.
REQ-006 SHALL have port req_key, input, DATA_WIDTH: key to search.
REQ-007 SHALL have port req_ready, output, 1: request accepted when high together with req_valid.
REQ-008 SHALL have port cam_key, output, DATA_WIDTH: registered key driven to the CAM RAM search-port data input.
REQ-009 SHALL have port cam_match_n, input, N: CAM RAM search output, registered in the RAM with one-cycle latency; bit i low = key stored at address i.
REQ-010 SHALL have port res_valid, output, 1: result available.
REQ-011 SHALL have port res_ready, input, 1: result consumed when high together with res_valid.
REQ-012 SHALL have port res_hit, output, 1: at least one entry matched.
REQ-013 SHALL have port res_addr, output, ADDR_WIDTH: lowest matching address; 0 on miss.
REQ-014 SHALL have port res_multi, output, 1: more than one entry matched.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ENCODE and RESULT.
REQ-016 SHALL drive req_ready high only in IDLE; all other states are busy.
REQ-017 SHALL, in IDLE on req_valid&&req_ready, register req_key into cam_key and go to WAIT.
REQ-018 SHALL hold cam_key constant from accept until the next accept.
REQ-019 SHALL spend exactly one cycle in WAIT, during which the RAM samples cam_key, then go to ENCODE.
REQ-020 SHALL, in ENCODE, sample cam_match_n once, compute the results, register them and go to RESULT.
REQ-021 SHALL assert res_valid in RESULT only; latency from accept edge to res_valid high is 3 cycles.
REQ-022 SHALL hold res_hit, res_addr and res_multi stable while res_valid is high and res_ready is low.
REQ-023 SHALL return to IDLE on the edge where res_valid&&res_ready; res_valid drops the next cycle.
REQ-024 SHALL give the lowest index the priority for res_addr.
REQ-025 SHALL set res_hit = ~&cam_match_n and res_multi = 1 when two or more bits are low.
REQ-026 SHALL report res_hit=0, res_addr=0, res_multi=0 for an all-ones cam_match_n.
REQ-027 SHALL make the result reflect the RAM contents read at the edge ending WAIT; RAM writes after that edge do not affect it.
REQ-028 SHALL ignore req_valid and req_key outside IDLE; no queuing, one search in flight.
REQ-029 SHALL sustain a maximum throughput of one search per 4 cycles with res_ready tied high.

Reset
REQ-030 SHALL, on rst high at an edge, force IDLE and clear res_valid, res_hit, res_addr, res_multi and cam_key to 0 (plus res_count when compiled in).
REQ-031 SHALL, on rst asserted mid-search (WAIT, ENCODE or RESULT), discard the in-flight search and produce no result.
REQ-032 SHALL hold req_ready low while rst is high and raise it the first cycle after rst is released.

Configuration
REQ-033 SHALL, with macro CAM_MATCH_COUNT_EN defined, add output res_count, ADDR_WIDTH+1 bits, equal to the number of low bits of cam_match_n, registered in ENCODE and held like the other results.
REQ-034 SHALL, without CAM_MATCH_COUNT_EN, omit the res_count port and its logic, leaving all other behaviour identical.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2)
REQ-035 SHALL cover: accept key 8'h3C, cam_match_n=4'b1011 -> cam_key=8'h3C one cycle after accept; res_valid 3 cycles after accept; res_hit=1, res_addr=2, res_multi=0, res_count=1.
REQ-036 SHALL cover: cam_match_n=4'b0101 -> res_hit=1, res_addr=1, res_multi=1, res_count=2.
REQ-037 SHALL cover: cam_match_n=4'b1111 -> res_hit=0, res_addr=0, res_multi=0, res_count=0.
REQ-038 SHALL cover: res_ready low for 5 cycles, req_valid high with key 8'hAA during that time -> result held unchanged, req_ready=0, cam_key unchanged; after the handshake, IDLE with req_ready=1 on the next cycle.
REQ-039 SHALL cover: rst pulsed for one cycle while in ENCODE -> no res_valid pulse, all outputs 0, req_ready=1 the cycle after rst drops.
REQ-040 SHALL cover: req_valid held high with res_ready=1 -> accepts spaced exactly 4 cycles apart.
